// File: rtl/psum_drain_pkg.sv
// Shared defaults, derived widths and state type for the psum output drain.
package psum_drain_pkg;

    localparam int DEF_COL     = 8;
    localparam int DEF_BW_PSUM = 20;
    localparam int DEF_DEPTH   = 4;

    localparam int COL_IDX_W = $clog2(DEF_COL);
    localparam int CNT_W     = $clog2(DEF_DEPTH) + 1;

    typedef enum logic {
        EMPTY = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

endpackage

// File: rtl/psum_row_fifo.sv
// Row FIFO for the psum drain: whole rows in, whole rows out, with occupancy count.
module psum_row_fifo
    import psum_drain_pkg::*;
#(
    parameter int WIDTH = DEF_COL * DEF_BW_PSUM,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic [WIDTH-1:0]       i_wdata,
    output logic [WIDTH-1:0]       o_rdata,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int FCNT_W = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [FCNT_W-1:0] r_count;

    // Storage is never read before it is written, so it needs no reset.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == FCNT_W'(DEPTH));

endmodule

// File: rtl/psum_drain.sv
// Psum output drain: buffers full rows and serializes them column by column.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int col     = DEF_COL,
    parameter int bw_psum = DEF_BW_PSUM,
    parameter int depth   = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [bw_psum*col-1:0]   in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [bw_psum-1:0]       out_data,
    output logic [$clog2(col)-1:0]   out_col,
    output logic                     out_last,
    output logic [$clog2(depth):0]   count,
    output logic                     overflow
);

    localparam int ColIdxW = $clog2(col);
    localparam int CntW    = $clog2(depth) + 1;

    logic [bw_psum*col-1:0] w_row;
    logic [CntW-1:0]        w_count;
    logic                   w_full;
    logic                   w_push;
    logic                   w_xfer;
    logic                   w_last;
    logic                   w_pop;

    logic [ColIdxW-1:0]     r_col_idx;
    logic                   r_overflow;
    drain_state_e           r_state;
    drain_state_e           w_next_state;

    assign in_ready = !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_xfer   = out_valid && out_ready;
    assign w_last   = (r_col_idx == ColIdxW'(col - 1));
    assign w_pop    = w_xfer && w_last;

    psum_row_fifo #(
        .WIDTH (bw_psum * col),
        .DEPTH (depth)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata (in_data),
        .o_rdata (w_row),
        .o_count (w_count),
        .o_full  (w_full)
    );

    // State register; the state mirrors whether any row is buffered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next state: leave EMPTY on any push, return once the only row is freed.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (w_pop && !w_push && (w_count == CntW'(1))) begin
                    w_next_state = EMPTY;
                end
            end
            default: w_next_state = EMPTY;
        endcase
    end

    // Column serializer: advance one word per transfer, wrap after the last column.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_col_idx <= '0;
        end else if (w_xfer) begin
            r_col_idx <= w_last ? '0 : r_col_idx + 1'b1;
        end
    end

    // Sticky flag for any row offered while the FIFO was full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_overflow <= 1'b0;
        end else if (in_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Output word select; forced to zero when nothing is buffered.
    always_comb begin
        out_data = '0;
        if (out_valid) begin
            out_data = w_row[r_col_idx * bw_psum +: bw_psum];
        end
    end

    assign out_valid = (r_state == DRAIN);
    assign out_col   = r_col_idx;
    assign out_last  = w_last;
    assign count     = w_count;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_psum_drain.sv
// Scoreboard bench for psum_drain: stimulus enqueues expected words, a monitor checks them.
module tb_psum_drain;

    localparam int COL = 8;
    localparam int BW  = 20;

    typedef struct packed {
        logic [BW-1:0] data;
        logic [2:0]    col;
        logic          last;
    } expWord_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [BW*COL-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [BW-1:0]    out_data;
    logic [2:0]       out_col;
    logic             out_last;
    logic [2:0]       count;
    logic             overflow;

    expWord_t sbQ[$];
    int errors = 0;
    int checks = 0;

    psum_drain dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_col   (out_col),
        .out_last  (out_last),
        .count     (count),
        .overflow  (overflow)
    );

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every valid cycle must match the head of the scoreboard; pop on transfer.
    always @(negedge clk) begin
        if (reset && out_valid) begin
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpectedWord: got data=%h col=%0d last=%0d, required no valid word",
                         out_data, out_col, out_last);
            end else begin
                if (out_data !== sbQ[0].data || out_col !== sbQ[0].col || out_last !== sbQ[0].last) begin
                    errors++;
                    $display("[TB] FAIL word: got data=%h col=%0d last=%0d, required data=%h col=%0d last=%0d",
                             out_data, out_col, out_last, sbQ[0].data, sbQ[0].col, sbQ[0].last);
                end
                if (out_ready) begin
                    void'(sbQ.pop_front());
                end
            end
        end
    end

    function automatic logic [BW*COL-1:0] makeRow(input logic [BW-1:0] base);
        logic [BW*COL-1:0] row;
        row = '0;
        for (int c = 0; c < COL; c++) begin
            row[c*BW +: BW] = base + BW'(c);
        end
        return row;
    endfunction

    task automatic enqueueRow(input logic [BW*COL-1:0] row);
        for (int c = 0; c < COL; c++) begin
            sbQ.push_back({row[c*BW +: BW], 3'(c), (c == COL - 1)});
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    // Offer one row for a single cycle; the caller states whether it should be taken.
    task automatic applyStimulus(input logic [BW*COL-1:0] row, input logic expectAccept, input string name);
        in_valid = 1'b1;
        in_data  = row;
        checkOutput({name, "_inReady"}, 32'(in_ready), 32'(expectAccept));
        if (expectAccept) begin
            enqueueRow(row);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input int bound, input string name);
        int n;
        n = 0;
        while ((sbQ.size() != 0 || out_valid) && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sbQ.size() != 0 || out_valid) begin
            errors++;
            $display("[TB] FAIL %s_timeout: got %0d words pending, required 0", name, sbQ.size());
        end
    endtask

    task automatic doReset();
        reset     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sbQ.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Directed test sequence.
    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #2;
        checkOutput("rst_outValid", 32'(out_valid), 32'd0);
        checkOutput("rst_outData",  32'(out_data),  32'd0);
        checkOutput("rst_outCol",   32'(out_col),   32'd0);
        checkOutput("rst_outLast",  32'(out_last),  32'd0);
        checkOutput("rst_inReady",  32'(in_ready),  32'd1);
        checkOutput("rst_count",    32'(count),     32'd0);
        checkOutput("rst_overflow", 32'(overflow),  32'd0);
        doReset();

        $display("[TB] single row drain");
        out_ready = 1'b1;
        applyStimulus(makeRow(20'h00001), 1'b1, "t1");
        checkOutput("t1_outValid", 32'(out_valid), 32'd1);
        checkOutput("t1_count", 32'(count), 32'd1);
        waitDrain(20, "t1");
        checkOutput("t1_endValid", 32'(out_valid), 32'd0);
        checkOutput("t1_endCount", 32'(count), 32'd0);

        $display("[TB] fill and overflow");
        out_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            applyStimulus(makeRow(BW'(32'h10000 * (r + 1))), 1'b1, "t2_fill");
        end
        checkOutput("t2_count", 32'(count), 32'd4);
        checkOutput("t2_inReady", 32'(in_ready), 32'd0);
        applyStimulus(makeRow(20'hABC00), 1'b0, "t2_extra");
        checkOutput("t2_overflow", 32'(overflow), 32'd1);
        checkOutput("t2_countHeld", 32'(count), 32'd4);
        out_ready = 1'b1;
        waitDrain(60, "t2");
        checkOutput("t2_endCount", 32'(count), 32'd0);
        checkOutput("t2_overflowSticky", 32'(overflow), 32'd1);
        doReset();
        checkOutput("t2_overflowCleared", 32'(overflow), 32'd0);

        $display("[TB] stalled drain");
        applyStimulus(makeRow(20'h00001), 1'b1, "t3");
        for (int i = 0; i < 40 && (sbQ.size() != 0 || out_valid); i++) begin
            out_ready = (i % 2 == 0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        waitDrain(20, "t3");

        $display("[TB] push during final pop while full");
        out_ready = 1'b0;
        for (int r = 0; r < 4; r++) begin
            applyStimulus(makeRow(BW'(32'h20000 + 32'h100 * r)), 1'b1, "t4_fill");
        end
        out_ready = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        checkOutput("t4_col7", 32'(out_col), 32'd7);
        in_valid = 1'b1;
        in_data  = makeRow(20'h2FF00);
        checkOutput("t4_inReadyFull", 32'(in_ready), 32'd0);
        checkOutput("t4_countFull", 32'(count), 32'd4);
        @(posedge clk);
        #1;
        checkOutput("t4_countAfterPop", 32'(count), 32'd3);
        checkOutput("t4_inReadyAfterPop", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        enqueueRow(makeRow(20'h2FF00));
        checkOutput("t4_countRefilled", 32'(count), 32'd4);
        waitDrain(60, "t4");
        checkOutput("t4_endCount", 32'(count), 32'd0);
        checkOutput("t4_overflow", 32'(overflow), 32'd1);
        doReset();

        $display("[TB] streaming with pointer wrap");
        out_ready = 1'b1;
        for (int r = 0; r < 10; r++) begin
            applyStimulus(makeRow(BW'(32'h30000 + 32'h10 * r)), 1'b1, "t5");
            checkOutput("t5_count", 32'(count), 32'd1);
            repeat (7) @(posedge clk);
            #1;
        end
        waitDrain(20, "t5");
        checkOutput("t5_overflow", 32'(overflow), 32'd0);
        checkOutput("t5_endCount", 32'(count), 32'd0);

        $display("[TB] reset mid-row");
        out_ready = 1'b0;
        applyStimulus(makeRow(20'h40000), 1'b1, "t6_fill");
        applyStimulus(makeRow(20'h41000), 1'b1, "t6_fill");
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6_col3", 32'(out_col), 32'd3);
        reset = 1'b0;
        sbQ.delete();
        #1;
        checkOutput("t6_asyncValid", 32'(out_valid), 32'd0);
        checkOutput("t6_asyncCount", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("t6_idleValid", 32'(out_valid), 32'd0);
        applyStimulus(makeRow(20'h50000), 1'b1, "t6_fresh");
        checkOutput("t6_freshCol", 32'(out_col), 32'd0);
        waitDrain(20, "t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no completion, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
